// File: rtl/img_proc_pkg.sv
// Shared pixel/gradient widths and small arithmetic helpers for the image
// processing chain.
package img_proc_pkg;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 12;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  // Zero-extend a pixel into the signed gradient domain.
  function automatic logic signed [GRAD_W-1:0] grad_ext(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic [PIX_W-1:0] sat_pix(input logic [MAG_W-1:0] mag);
    return (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/sobel_edge_stage_if.sv
// Pixel stream in and edge-magnitude stream out of the Sobel stage.
// Handshake: valid-only, no ready; a beat transfers on every rising edge with valid high.
interface sobel_edge_stage_if;
  import img_proc_pkg::*;
  logic [PIX_W-1:0] gray_in;
  logic             valid_in;
  logic             sof;
  logic [PIX_W-1:0] edge_out;
  logic             edge_valid;
  logic             frame_done;

  modport master (output gray_in, valid_in, sof, input edge_out, edge_valid, frame_done);
  modport slave  (input gray_in, valid_in, sof, output edge_out, edge_valid, frame_done);
endinterface

// File: rtl/line_buffer.sv
// One image line of pixel storage addressed by column; the read returns the
// previous line's pixel at that column before it is overwritten.
module line_buffer
  import img_proc_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
  end
endmodule

// File: rtl/sobel_edge_stage.sv
// Streaming 3x3 Sobel magnitude: two line buffers feed a 3x3 window, then a
// two-register datapath produces min(|Gx|+|Gy|, 255) for interior pixels.
module sobel_edge_stage
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_edge_stage_if.slave  s
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          accept;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;

  // win[row][col]: row 0 is two lines up, col 2 is the newest column.
  logic [PIX_W-1:0] win [3][3];
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic signed [GRAD_W-1:0] gx_c, gy_c, gx_q, gy_q;
  logic [GRAD_W-1:0] ax, ay;
  logic [MAG_W-1:0]  mag;

  assign accept = s.valid_in;

  // sof relabels the incoming pixel as (0,0) regardless of the running count.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (s.sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col),
    .wr_data (s.gray_in),
    .rd_data (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb2 (
    .clk     (clk),
    .en      (accept),
    .addr    (cur_col),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= s.gray_in;
        // A full window of current-frame columns c-2..c exists only from (2,2) on.
        s1_valid  <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        s1_last   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  always_comb begin
    gx_c = (grad_ext(win[0][2]) + (grad_ext(win[1][2]) <<< 1) + grad_ext(win[2][2]))
         - (grad_ext(win[0][0]) + (grad_ext(win[1][0]) <<< 1) + grad_ext(win[2][0]));
    gy_c = (grad_ext(win[2][0]) + (grad_ext(win[2][1]) <<< 1) + grad_ext(win[2][2]))
         - (grad_ext(win[0][0]) + (grad_ext(win[0][1]) <<< 1) + grad_ext(win[0][2]));
  end

  always_comb begin
    ax  = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
    ay  = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
    mag = MAG_W'(ax) + MAG_W'(ay);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      s2_last      <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      s.edge_out   <= '0;
      s.edge_valid <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        gx_q <= gx_c;
        gy_q <= gy_c;
      end
      s.edge_valid <= s2_valid;
      s.frame_done <= s2_valid && s2_last;
      if (s2_valid) s.edge_out <= sat_pix(mag);
    end
  end
endmodule
